mod5_seq_checker: RTL and testbench

Sequence checker and terminal-count generator that sits directly downstream of the 3-bit mod-5 (0→1→2→3→4→0) counter. It samples the counter's 3-bit output every clock and checks that each value is the legal successor of the previous one. It emits a one-cycle terminal-count pulse on every 4→0 wrap and keeps a saturating wrap count. Any illegal value or transition sets a sticky error flag until software clears it and the checker resynchronises.

---
 rtl/mod5_seq_checker_if.sv | 30 +++
 rtl/mod5_seq_checker.sv | 85 ++++++++
 tb/tb_mod5_seq_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mod5_seq_checker_if.sv
// Bundle of signals between the mod-5 counter and its checker.
// The counter side (master) drives the sample and clear request. The checker side (slave) returns the status.
interface mod5_seq_checker_if #(
  parameter int WRAP_W = 8
);
  logic [2:0]        cnt;
  logic              clr_err;
  logic              tc;
  logic [WRAP_W-1:0] wraps;
  logic              err;
  logic [1:0]        state;

  modport master (
    output cnt,
    output clr_err,
    input  tc,
    input  wraps,
    input  err,
    input  state
  );

  modport slave (
    input  cnt,
    input  clr_err,
    output tc,
    output wraps,
    output err,
    output state
  );
endinterface

// File: rtl/mod5_seq_checker.sv
// Checks that a free-running mod-5 counter steps 0->1->2->3->4->0 on every clock.
// It emits a terminal-count pulse on each 4->0 wrap and keeps a saturating count of those wraps.
module mod5_seq_checker #(
  parameter int WRAP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mod5_seq_checker_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t            state_q, state_nxt;
  logic [2:0]        prev_q, prev_nxt;
  logic              tc_q, tc_nxt;
  logic [WRAP_W-1:0] wraps_q, wraps_nxt;
  logic [2:0]        exp_cnt;

  // The upstream counter has no enable, so a held value is as wrong as a skipped one.
  assign exp_cnt = (prev_q == 3'd4) ? 3'd0 : prev_q + 3'd1;

  // State register together with the sample, pulse and wrap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= 3'd0;
      tc_q    <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_nxt;
      prev_q  <= prev_nxt;
      tc_q    <= tc_nxt;
      wraps_q <= wraps_nxt;
    end
  end

  // Next-state and next-data logic.
  always_comb begin
    state_nxt = state_q;
    prev_nxt  = prev_q;
    tc_nxt    = 1'b0;
    wraps_nxt = wraps_q;
    case (state_q)
      IDLE: begin
        prev_nxt  = bus.cnt;
        state_nxt = (bus.cnt <= 3'd4) ? TRACK : FAULT;
      end
      TRACK: begin
        if (bus.cnt == exp_cnt) begin
          prev_nxt = bus.cnt;
          if (prev_q == 3'd4) begin
            tc_nxt = 1'b1;
            if (wraps_q != '1) begin
              wraps_nxt = wraps_q + WRAP_W'(1);
            end
          end
        end else begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        // Clearing ignores the current sample; IDLE recaptures it on the next edge.
        if (bus.clr_err) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered values only.
  always_comb begin
    bus.err   = (state_q == FAULT);
    bus.tc    = tc_q;
    bus.wraps = wraps_q;
    bus.state = state_q;
  end

endmodule

// File: tb/tb_mod5_seq_checker.sv
// Bench for mod5_seq_checker. It drives two instances (WRAP_W=8 and WRAP_W=2) from one stimulus stream.
// A behavioural model predicts the outputs of both instances.
module tb_mod5_seq_checker;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // model state
  bit   m_synced;
  bit   m_fault;
  int   m_ref;
  bit   m_tc;
  int   m_wraps8;
  int   m_wraps2;

  mod5_seq_checker_if #(.WRAP_W(8)) bus8 ();
  mod5_seq_checker_if #(.WRAP_W(2)) bus2 ();

  mod5_seq_checker #(.WRAP_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  mod5_seq_checker #(.WRAP_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour, described by synced/fault flags and a modulo-5 successor rule.
  task automatic model_update(input int c, input bit clr, input bit r);
    if (r) begin
      m_synced = 0; m_fault = 0; m_ref = 0; m_tc = 0;
      m_wraps8 = 0; m_wraps2 = 0;
    end else if (m_fault) begin
      m_tc = 0;
      if (clr) m_fault = 0;
    end else if (!m_synced) begin
      m_tc  = 0;
      m_ref = c;
      if (c < 5) m_synced = 1;
      else       m_fault  = 1;
    end else if (c == (m_ref + 1) % 5) begin
      m_tc = (c == 0);
      if (m_tc) begin
        if (m_wraps8 < 255) m_wraps8++;
        if (m_wraps2 < 3)   m_wraps2++;
      end
      m_ref = c;
    end else begin
      m_tc = 0; m_fault = 1; m_synced = 0;
    end
  endtask

  function automatic int exp_state();
    if (m_fault)  return 2;
    if (m_synced) return 1;
    return 0;
  endfunction

  task automatic compare_all();
    check("state8", 32'(bus8.state), 32'(exp_state()));
    check("err8",   32'(bus8.err),   32'(m_fault));
    check("tc8",    32'(bus8.tc),    32'(m_tc));
    check("wraps8", 32'(bus8.wraps), 32'(m_wraps8));
    check("state2", 32'(bus2.state), 32'(exp_state()));
    check("err2",   32'(bus2.err),   32'(m_fault));
    check("tc2",    32'(bus2.tc),    32'(m_tc));
    check("wraps2", 32'(bus2.wraps), 32'(m_wraps2));
  endtask

  // driver: apply one sample, let one edge pass, then compare 1 ns later
  task automatic step(input int c, input bit clr, input bit r);
    bus8.cnt = 3'(c); bus2.cnt = 3'(c);
    bus8.clr_err = clr; bus2.clr_err = clr;
    rst = r;
    @(posedge clk);
    model_update(c, clr, r);
    #1;
    compare_all();
  endtask

  initial begin
    int cur;
    int v;
    bit clr;
    bit r;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus8.cnt = '0; bus2.cnt = '0;
    bus8.clr_err = 1'b0; bus2.clr_err = 1'b0;
    model_update(0, 0, 1);

    // reset, with clr_err and an illegal count present
    step(7, 1, 1);
    step(0, 0, 1);
    check("reset_state", 32'(bus8.state), 32'd0);
    check("reset_tc",    32'(bus8.tc),    32'd0);

    // 21 legal samples: tc after samples 6, 11, 16 and 21
    for (int i = 0; i < 21; i++) step(i % 5, 0, 0);
    check("legal_wraps", 32'(bus8.wraps), 32'd4);
    check("legal_err",   32'(bus8.err),   32'd0);

    // illegal value at prev=2, then the legal sequence continues while in FAULT
    step(1, 0, 0);
    step(2, 0, 0);
    step(6, 0, 0);
    check("bad_err", 32'(bus8.err), 32'd1);
    for (int i = 3; i < 10; i++) step(i % 5, 0, 0);
    check("frozen_wraps", 32'(bus8.wraps), 32'd4);

    // clear while cnt=3, recapture 3, then wrap via 4,0
    step(3, 1, 0);
    check("clr_state", 32'(bus8.state), 32'd0);
    step(3, 0, 0);
    step(4, 0, 0);
    step(0, 0, 0);
    check("resync_tc",    32'(bus8.tc),    32'd1);
    check("resync_wraps", 32'(bus8.wraps), 32'd5);

    // held value
    step(1, 0, 0);
    step(2, 0, 0);
    step(2, 0, 0);
    check("hold_err", 32'(bus8.err), 32'd1);

    // clear with an illegal count: IDLE first, then FAULT again
    step(5, 1, 0);
    step(5, 0, 0);
    check("reenter_fault", 32'(bus8.state), 32'd2);
    step(0, 1, 0);

    // six full wraps to saturate the narrow counter
    for (int i = 0; i < 31; i++) step(i % 5, 0, 0);
    check("sat_wraps2", 32'(bus2.wraps), 32'd3);

    // reset while in FAULT with clr_err high, then resume from 0
    step(1, 0, 0);
    step(1, 0, 0);
    step(4, 1, 1);
    check("rst_fault_wraps", 32'(bus8.wraps), 32'd0);
    for (int i = 0; i < 12; i++) step(i % 5, 0, 0);
    check("rst_resume_err", 32'(bus8.err), 32'd0);

    // randomized phase: mostly legal counting with glitches, clears and resets
    cur = 0;
    for (int i = 0; i < 600; i++) begin
      v = cur;
      if ($urandom_range(0, 15) == 0) v = int'($urandom_range(0, 7));
      clr = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 99) == 0);
      step(v, clr, r);
      cur = (cur + 1) % 5;
      if (r) cur = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
